// File: rtl/tpu_avalon_slave.sv
// Avalon-MM slave bridging the HPS bus to the TPU memories and command sequencer.
// One window holds the CSRs and the input/weight/output memories; wide TPU rows are split into bus beats.
module tpu_avalon_slave #(
  parameter int DATA_WIDTH   = 64,
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int TIMEOUT      = 4096,
  parameter int RST_CYCLES   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       slave_address,
  input  logic                        slave_read,
  input  logic                        slave_write,
  input  logic [DATA_WIDTH-1:0]       slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]     slave_byteenable,
  output logic [DATA_WIDTH-1:0]       slave_readdata,
  output logic                        slave_readdatavalid,
  output logic                        tpu_reset,
  output logic                        tpu_active,
  output logic                        fill_fifo,
  output logic                        drain_fifo,
  output logic [WIDTH_HEIGHT-1:0]     inputMem_wr_en,
  output logic [WIDTH_HEIGHT-1:0]     weightMem_wr_en,
  output logic [WIDTH_HEIGHT-1:0]     outputMem_rd_en,
  output logic [8*WIDTH_HEIGHT-1:0]   inputMem_wr_addr,
  output logic [8*WIDTH_HEIGHT-1:0]   weightMem_wr_addr,
  output logic [8*WIDTH_HEIGHT-1:0]   outputMem_rd_addr,
  output logic [8*WIDTH_HEIGHT-1:0]   inputMem_wr_data,
  output logic [8*WIDTH_HEIGHT-1:0]   weightMem_wr_data,
  input  logic [8*WIDTH_HEIGHT-1:0]   outputMem_rd_data,
  output logic [7:0]                  inputMem_rd_addr_base,
  output logic [7:0]                  weightMem_rd_addr_base,
  output logic [7:0]                  outputMem_wr_addr_base,
  input  logic                        mem_to_fifo_done,
  input  logic                        fifo_to_arr_done,
  input  logic                        output_done
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int BEATS = (WIDTH_HEIGHT / BPW > 1) ? WIDTH_HEIGHT / BPW : 1;
  localparam int LGB   = $clog2(BEATS);
  localparam int OFFW  = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_FIFO = 3'd1,
    FILL_ARR  = 3'd2,
    MULTIPLY  = 3'd3,
    SRST      = 3'd4
  } stateT;

  stateT state, stateNext;

  logic [1:0]            region;
  logic [OFFW-1:0]       offset;
  logic [OFFW-1:0]       beatIdx;
  logic [7:0]            rowAddr;
  logic [7:0]            cmdCode;
  logic                  busy;
  logic                  csrWrite, cmdWrite, cmdValid, cmdAccept, cmdErr;
  logic                  memWrite, memWriteErr, outRead, statusRead;
  logic                  doneHit, abortHit, timeoutNow;
  logic [15:0]           rstCnt;
  logic [31:0]           cycles;
  logic                  doneFlag, errFlag, timeoutFlag;
  logic [DATA_WIDTH-1:0] csrRdata, csrData1, outSlice;
  logic                  rdValid1, rdOut1;
  logic [OFFW-1:0]       rdBeat1;

  assign region     = slave_address[ADDR_WIDTH-1 -: 2];
  assign offset     = slave_address[OFFW-1:0];
  assign beatIdx    = offset & OFFW'(BEATS - 1);
  assign rowAddr    = 8'(offset >> LGB);
  assign cmdCode    = slave_writedata[7:0];
  assign busy       = (state != IDLE);

  assign csrWrite    = slave_write && (region == 2'b00);
  assign cmdWrite    = csrWrite && (offset == OFFW'(0));
  assign cmdValid    = cmdCode inside {8'h01, 8'h02, 8'h03, 8'h0F};
  assign cmdAccept   = cmdWrite && cmdValid && !busy;
  assign cmdErr      = cmdWrite && (busy || !cmdValid);
  assign memWrite    = slave_write && ((region == 2'b01) || (region == 2'b10));
  assign memWriteErr = memWrite && busy;
  assign outRead     = slave_read && (region == 2'b11);
  assign statusRead  = slave_read && (region == 2'b00) && (offset == OFFW'(1));
  assign timeoutNow  = (TIMEOUT != 0) && (cycles == 32'(TIMEOUT - 1));

  assign inputMem_wr_addr  = {WIDTH_HEIGHT{rowAddr}};
  assign weightMem_wr_addr = {WIDTH_HEIGHT{rowAddr}};
  assign outputMem_rd_addr = {WIDTH_HEIGHT{rowAddr}};

  // Column c belongs to beat c/BPW and is fed from byte lane c%BPW; writes are dropped while a command runs.
  always_comb begin
    inputMem_wr_en    = '0;
    weightMem_wr_en   = '0;
    outputMem_rd_en   = '0;
    inputMem_wr_data  = '0;
    weightMem_wr_data = '0;
    for (int c = 0; c < WIDTH_HEIGHT; c++) begin
      inputMem_wr_en[c]  = memWrite && !busy && !reset && (region == 2'b01) &&
                           (beatIdx == OFFW'(c / BPW)) && slave_byteenable[c % BPW];
      weightMem_wr_en[c] = memWrite && !busy && !reset && (region == 2'b10) &&
                           (beatIdx == OFFW'(c / BPW)) && slave_byteenable[c % BPW];
      outputMem_rd_en[c] = outRead && !reset && (beatIdx == OFFW'(c / BPW));
      inputMem_wr_data[8*c +: 8]  = slave_writedata[8*(c % BPW) +: 8];
      weightMem_wr_data[8*c +: 8] = slave_writedata[8*(c % BPW) +: 8];
    end
  end

  // Command sequencer: each busy state holds its TPU strobe until the matching done pulse or the timeout.
  always_comb begin
    stateNext  = state;
    tpu_reset  = 1'b0;
    tpu_active = 1'b0;
    fill_fifo  = 1'b0;
    drain_fifo = 1'b0;
    doneHit    = 1'b0;
    abortHit   = 1'b0;
    case (state)
      IDLE: begin
        if (cmdAccept) begin
          case (cmdCode)
            8'h01:   stateNext = FILL_FIFO;
            8'h02:   stateNext = FILL_ARR;
            8'h03:   stateNext = MULTIPLY;
            8'h0F:   stateNext = SRST;
            default: stateNext = IDLE;
          endcase
        end
      end
      FILL_FIFO: begin
        fill_fifo = 1'b1;
        if (mem_to_fifo_done) begin
          stateNext = IDLE;
          doneHit   = 1'b1;
        end else if (timeoutNow) begin
          stateNext = IDLE;
          abortHit  = 1'b1;
        end
      end
      FILL_ARR: begin
        drain_fifo = 1'b1;
        if (fifo_to_arr_done) begin
          stateNext = IDLE;
          doneHit   = 1'b1;
        end else if (timeoutNow) begin
          stateNext = IDLE;
          abortHit  = 1'b1;
        end
      end
      MULTIPLY: begin
        tpu_active = 1'b1;
        if (output_done) begin
          stateNext = IDLE;
          doneHit   = 1'b1;
        end else if (timeoutNow) begin
          stateNext = IDLE;
          abortHit  = 1'b1;
        end
      end
      SRST: begin
        tpu_reset = 1'b1;
        if (rstCnt == 16'(RST_CYCLES - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rstCnt <= '0;
    end else begin
      state  <= stateNext;
      rstCnt <= (state == SRST && stateNext == SRST) ? rstCnt + 16'd1 : '0;
    end
  end

  // Later assignments win, so a flag being set beats a STATUS read clearing it in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles                 <= '0;
      doneFlag               <= 1'b0;
      errFlag                <= 1'b0;
      timeoutFlag            <= 1'b0;
      inputMem_rd_addr_base  <= '0;
      weightMem_rd_addr_base <= '0;
      outputMem_wr_addr_base <= '0;
    end else begin
      if (cmdAccept) cycles <= '0;
      else if (busy) cycles <= cycles + 32'd1;
      if (statusRead) begin
        doneFlag    <= 1'b0;
        errFlag     <= 1'b0;
        timeoutFlag <= 1'b0;
      end
      if (cmdAccept) begin
        doneFlag <= 1'b0;
        if (cmdCode == 8'h0F) begin
          errFlag                <= 1'b0;
          timeoutFlag            <= 1'b0;
          inputMem_rd_addr_base  <= '0;
          weightMem_rd_addr_base <= '0;
          outputMem_wr_addr_base <= '0;
        end
      end
      if (csrWrite && slave_byteenable[0]) begin
        case (offset)
          OFFW'(2): inputMem_rd_addr_base  <= slave_writedata[7:0];
          OFFW'(3): weightMem_rd_addr_base <= slave_writedata[7:0];
          OFFW'(4): outputMem_wr_addr_base <= slave_writedata[7:0];
          default: ;
        endcase
      end
      if (doneHit) doneFlag <= 1'b1;
      if (cmdErr || memWriteErr || abortHit) errFlag <= 1'b1;
      if (abortHit) timeoutFlag <= 1'b1;
    end
  end

  always_comb begin
    csrRdata = '0;
    if (region == 2'b00) begin
      case (offset)
        OFFW'(1): csrRdata = DATA_WIDTH'({state, timeoutFlag, errFlag, doneFlag, busy});
        OFFW'(2): csrRdata = DATA_WIDTH'(inputMem_rd_addr_base);
        OFFW'(3): csrRdata = DATA_WIDTH'(weightMem_rd_addr_base);
        OFFW'(4): csrRdata = DATA_WIDTH'(outputMem_wr_addr_base);
        OFFW'(5): csrRdata = DATA_WIDTH'(cycles);
        default:  csrRdata = '0;
      endcase
    end
  end

  always_comb begin
    outSlice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (rdBeat1 == OFFW'(b)) outSlice = outputMem_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Two-stage read pipeline: CSR values are captured at accept, memory rows arrive one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdValid1            <= 1'b0;
      rdOut1              <= 1'b0;
      rdBeat1             <= '0;
      csrData1            <= '0;
      slave_readdatavalid <= 1'b0;
      slave_readdata      <= '0;
    end else begin
      rdValid1            <= slave_read;
      rdOut1              <= outRead;
      rdBeat1             <= beatIdx;
      csrData1            <= csrRdata;
      slave_readdatavalid <= rdValid1;
      slave_readdata      <= rdValid1 ? (rdOut1 ? outSlice : csrData1) : '0;
    end
  end

endmodule
